// File: rtl/mem_access_unit_pkg.sv
// Shared constants, state encoding and legality helpers for the memory access unit.
package mem_access_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    localparam logic [6:0] LOAD_OPCODE  = 7'b0000011;
    localparam logic [6:0] STORE_OPCODE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } mau_state_t;

    // Stores only accept the signed size codes; loads also accept BU/HU.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // Size lives in funct3[1:0]; only meaningful once f3_legal holds.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory valid/grant/rvalid handshake between the memory stage and memory.
interface mem_access_unit_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
);
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [AWIDTH-1:0]     mem_addr_o;
    logic [DWIDTH/8-1:0]   mem_be_o;
    logic [DWIDTH-1:0]     mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DWIDTH-1:0]     mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_access_unit_mem_align.sv
// Byte-lane placement for stores and lane extraction/extension for loads.
module mem_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]        st_off_i,
    input  logic [2:0]        st_funct3_i,
    input  logic [DATA_W-1:0] st_data_i,
    output logic [BE_W-1:0]   st_be_o,
    output logic [DATA_W-1:0] st_wdata_o,
    input  logic [1:0]        ld_off_i,
    input  logic [2:0]        ld_funct3_i,
    input  logic [DATA_W-1:0] ld_rdata_i,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Store direction: the same lane pattern is used for loads of that size.
    always_comb begin
        st_be_o    = '1;
        st_wdata_o = st_data_i;
        unique case (st_funct3_i[1:0])
            2'b00: begin
                st_be_o    = BE_W'(4'b0001 << st_off_i);
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_c = ld_rdata_i[7:0];
        unique case (ld_off_i)
            2'd0: byte_c = ld_rdata_i[7:0];
            2'd1: byte_c = ld_rdata_i[15:8];
            2'd2: byte_c = ld_rdata_i[23:16];
            2'd3: byte_c = ld_rdata_i[31:24];
            default: ;
        endcase
        half_c = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

        ld_data_o = ld_rdata_i;
        unique case (ld_funct3_i)
            F3_B:    ld_data_o = {{(DATA_W-8){byte_c[7]}}, byte_c};
            F3_BU:   ld_data_o = {{(DATA_W-8){1'b0}}, byte_c};
            F3_H:    ld_data_o = {{(DATA_W-16){half_c[15]}}, half_c};
            F3_HU:   ld_data_o = {{(DATA_W-16){1'b0}}, half_c};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: runs one load/store over the data-memory handshake, stalling upstream meanwhile.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] store_data_i,
    output logic              stall_o,
    output logic              done_o,
    output logic              fault_o,
    output logic [DWIDTH-1:0] load_data_o,
    mem_access_unit_if.master mem_if
);

    mau_state_t        state_q, state_d;
    logic              req_q, req_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic [DWIDTH-1:0] load_data_q, load_data_d;

    logic              we_q;
    logic [1:0]        off_q;
    logic [2:0]        funct3_q;
    logic [AWIDTH-1:0] addr_q;
    logic [BE_W-1:0]   be_q;
    logic [DWIDTH-1:0] wdata_q;

    logic              is_load_c;
    logic              is_store_c;
    logic              start_c;
    logic              bad_c;
    logic [BE_W-1:0]   be_c;
    logic [DWIDTH-1:0] wdata_c;
    logic [DWIDTH-1:0] ld_ext_c;

    assign is_load_c  = (opcode_i == LOAD_OPCODE);
    assign is_store_c = (opcode_i == STORE_OPCODE);
    assign start_c    = valid_i && (state_q == IDLE) && (is_load_c || is_store_c);
    assign bad_c      = !f3_legal(is_store_c, funct3_i) || misaligned(funct3_i, addr_i[1:0]);

    assign stall_o = start_c || (state_q == REQ) || (state_q == RESP);

    mem_align u_align (
        .st_off_i    (addr_i[1:0]),
        .st_funct3_i (funct3_i),
        .st_data_i   (store_data_i),
        .st_be_o     (be_c),
        .st_wdata_o  (wdata_c),
        .ld_off_i    (off_q),
        .ld_funct3_i (funct3_q),
        .ld_rdata_i  (mem_if.mem_rdata_i),
        .ld_data_o   (ld_ext_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            load_data_q <= load_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = 1'b0;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        load_data_d = load_data_q;
        unique case (state_q)
            IDLE: begin
                if (start_c) begin
                    if (bad_c) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        fault_d     = 1'b1;
                        load_data_d = '0;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_if.mem_gnt_i) begin
                    state_d = we_q ? DONE : RESP;
                    done_d  = we_q;
                end else begin
                    req_d = 1'b1;
                end
            end
            RESP: begin
                if (mem_if.mem_rvalid_i) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    load_data_d = ld_ext_c;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Access fields are captured once at start and held stable for the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q     <= 1'b0;
            off_q    <= 2'b00;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
        end else if (start_c) begin
            we_q     <= is_store_c;
            off_q    <= addr_i[1:0];
            funct3_q <= funct3_i;
            addr_q   <= {addr_i[AWIDTH-1:2], 2'b00};
            be_q     <= be_c;
            wdata_q  <= wdata_c;
        end
    end

    assign done_o      = done_q;
    assign fault_o     = fault_q;
    assign load_data_o = load_data_q;

    assign mem_if.mem_req_o   = req_q;
    assign mem_if.mem_we_o    = we_q;
    assign mem_if.mem_addr_o  = addr_q;
    assign mem_if.mem_be_o    = be_q;
    assign mem_if.mem_wdata_o = wdata_q;

endmodule
